// File: rtl/freq_gate_ctrl.sv
// Gate-time controller for the frequency counter datapath.
// Clears the edge counter, gates it, settles, then hands off the count.
module freq_gate_ctrl #(
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 50000,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic [CNT_W-1:0] edge_cnt_in,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_ovf,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [GW-1:0] GATE_LAST =
    GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST =
    SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    SETTLE,
    HOLD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [GW-1:0]    gate_q;
  logic [SW-1:0]    settle_q;
  logic [CNT_W-1:0] prev_q;
  logic             ovf_q;

  logic gate_done;
  logic settle_done;
  logic track;
  logic wrap;
  logic enter_hold;

  assign gate_done   = (gate_q == GATE_LAST);
  assign settle_done = (settle_q == SETTLE_LAST);
  assign track       = (state_q == GATE) ||
                       (state_q == SETTLE);
  assign wrap        = track &&
                       (edge_cnt_in < prev_q);
  assign enter_hold  = (state_q == SETTLE) &&
                       (state_d == HOLD);

  // State register
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state outputs; abort overrides everything
  always_comb begin
    state_d      = state_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_clr = 1'b1;
        state_d = GATE;
      end
      GATE: begin
        cnt_en = 1'b1;
        if (gate_done) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_done) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_d = cont ? CLEAR : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  // Gate and settle cycle counters, zero outside their state
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      gate_q   <= '0;
      settle_q <= '0;
    end else begin
      if (state_q == GATE && state_d == GATE) begin
        gate_q <= gate_q + GW'(1);
      end else begin
        gate_q <= '0;
      end
      if (state_q == SETTLE &&
          state_d == SETTLE) begin
        settle_q <= settle_q + SW'(1);
      end else begin
        settle_q <= '0;
      end
    end
  end

  // Sticky wrap detector on the live count
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      prev_q <= '0;
      ovf_q  <= 1'b0;
    end else if (state_q == CLEAR) begin
      prev_q <= '0;
      ovf_q  <= 1'b0;
    end else if (track) begin
      prev_q <= edge_cnt_in;
      if (wrap) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Result capture on HOLD entry; held until the next capture
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      result     <= '0;
      result_ovf <= 1'b0;
    end else if (enter_hold) begin
      result     <= edge_cnt_in;
      result_ovf <= ovf_q | wrap;
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Scoreboard bench for freq_gate_ctrl.
// Stub edge counter: preset on clear, +1 per enabled cycle.
module tb_freq_gate_ctrl;

  localparam int CNT_W = 16;
  localparam int G     = 8;
  localparam int S     = 2;

  typedef struct packed {
    logic [CNT_W-1:0] r;
    logic             o;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             cont;
  logic             abort;
  logic [CNT_W-1:0] stub = '0;
  logic [CNT_W-1:0] preset;
  logic             cnt_clr;
  logic             cnt_en;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic             result_ovf;
  logic             result_valid;
  logic             ready;

  exp_t q[$];
  exp_t mon_e;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  // Behavioural Edge_counter stand-in
  always @(posedge clk) begin
    if (cnt_clr) stub <= preset;
    else if (cnt_en) stub <= stub + 16'd1;
  end

  freq_gate_ctrl #(
    .CNT_W(CNT_W),
    .GATE_CYCLES(G),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk),
    .async_rst_n(rst_n),
    .start(start),
    .cont(cont),
    .abort(abort),
    .edge_cnt_in(stub),
    .cnt_clr(cnt_clr),
    .cnt_en(cnt_en),
    .busy(busy),
    .result(result),
    .result_ovf(result_ovf),
    .result_valid(result_valid),
    .result_ready(ready)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int maxc,
                            output int n);
    n = 0;
    while (!result_valid && n < maxc) begin
      tick();
      n++;
    end
    if (!result_valid)
      chk("valid_timeout", 32'(result_valid), 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_clr"}, 32'(cnt_clr), 0);
    chk({nm, "_en"}, 32'(cnt_en), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_res"}, 32'(result), 0);
    chk({nm, "_ovf"}, 32'(result_ovf), 0);
    chk({nm, "_vld"}, 32'(result_valid), 0);
  endtask

  initial begin
    int n;
    int clrs;
    int ens;
    int first;
    int vc;
    int vidx[3];
    logic seen;

    rst_n  = 1'b0;
    start  = 1'b0;
    cont   = 1'b0;
    abort  = 1'b0;
    ready  = 1'b0;
    preset = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && result_valid && ready) begin
          if (q.size() == 0) begin
            chk("unexpected_result",
                32'(result_valid), 0);
          end else begin
            mon_e = q.pop_front();
            chk("result", 32'(result),
                32'(mon_e.r));
            chk("result_ovf", 32'(result_ovf),
                32'(mon_e.o));
          end
        end
      end
    join_none

    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single shot
    ready = 1'b1;
    tick();
    start = 1'b1;
    q.push_back('{r: 16'd8, o: 1'b0});
    clrs  = 0;
    ens   = 0;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      clrs += int'(cnt_clr);
      ens  += int'(cnt_en);
      if (result_valid && first < 0) first = i;
    end
    chk("ss_latency", 32'(first), 12);
    chk("ss_clr_cycles", 32'(clrs), 1);
    chk("ss_en_cycles", 32'(ens), G);
    chk("ss_idle", 32'(busy), 0);

    // backpressure, then continuous
    ready = 1'b0;
    cont  = 1'b1;
    start = 1'b1;
    q.push_back('{r: 16'd8, o: 1'b0});
    tick();
    start = 1'b0;
    wait_valid(30, n);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(result_valid), 1);
      chk("bp_result", 32'(result), 8);
      chk("bp_en", 32'(cnt_en), 0);
      tick();
    end
    ready = 1'b1;
    for (int i = 0; i < 3; i++)
      q.push_back('{r: 16'd8, o: 1'b0});
    tick();
    chk("clear_after_ready", 32'(cnt_clr), 1);
    clrs = 1;
    vc   = 0;
    n    = 0;
    while (vc < 3 && n < 60) begin
      tick();
      n++;
      clrs += int'(cnt_clr);
      if (result_valid) begin
        vidx[vc] = n;
        vc++;
        if (vc == 3) cont = 1'b0;
      end
    end
    chk("cont_count", 32'(vc), 3);
    chk("cont_v0", 32'(vidx[0]), 11);
    chk("cont_v1", 32'(vidx[1]), 23);
    chk("cont_v2", 32'(vidx[2]), 35);
    chk("cont_clrs", 32'(clrs), 3);
    tick();
    chk("cont_stop", 32'(busy), 0);

    // overflow
    preset = 16'hFFFC;
    start  = 1'b1;
    q.push_back('{r: 16'h0004, o: 1'b1});
    tick();
    start = 1'b0;
    wait_valid(30, n);
    tick();
    tick();
    chk("ovf_idle", 32'(busy), 0);
    chk("ovf_kept", 32'(result), 4);
    preset = '0;

    // abort beats start
    start = 1'b1;
    abort = 1'b1;
    tick();
    chk("abort_start", 32'(busy), 0);
    start = 1'b0;
    abort = 1'b0;

    // abort at gate cycle 4
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre_abort_en", 32'(cnt_en), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_en", 32'(cnt_en), 0);
    chk("abort_clr", 32'(cnt_clr), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_vld", 32'(result_valid), 0);
    chk("abort_res", 32'(result), 4);
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= result_valid;
    end
    chk("abort_no_valid", 32'(seen), 0);

    // asynchronous reset mid-gate, mid-cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= result_valid | busy;
    end
    chk("rst_quiet", 32'(seen), 0);

    chk("queue_empty", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
